keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 205 ++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Brief    : 4x4 matrix keypad scanner. Drives one active-low column at a
//            time, debounces a single-key press and its release, and reports
//            each accepted key exactly once as a 4-bit code.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
  parameter int SCAN_DIV        = 10000,
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic [3:0] keypad_o,
  output logic       key_detect_o,
  output logic       key_held_o
);

  // One shared counter serves both the column dwell and the debounce windows.
  localparam int MAX_COUNT = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CNT_W     = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [2:0] SCAN         = 3'd0;
  localparam logic [2:0] DEBOUNCE     = 3'd1;
  localparam logic [2:0] PRESSED      = 3'd2;
  localparam logic [2:0] WAIT_RELEASE = 3'd3;
  localparam logic [2:0] REL_DEBOUNCE = 3'd4;

  logic [3:0]       row_meta;
  logic [3:0]       rows_s;
  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [1:0]       col_idx;
  logic [1:0]       col_idx_nxt;
  logic [3:0]       row_pat;
  logic [3:0]       row_pat_nxt;
  logic [3:0]       keypad_nxt;
  logic             detect_nxt;
  logic             held_nxt;
  logic             single_low;
  logic             rows_idle;
  logic [1:0]       row_idx;
  logic [3:0]       key_code;

  // Exactly one row pulled low means exactly one key on the driven column.
  assign single_low = (rows_s == 4'b1110) || (rows_s == 4'b1101) ||
                      (rows_s == 4'b1011) || (rows_s == 4'b0111);
  assign rows_idle  = (rows_s == 4'b1111);

  // Two-flop synchronizer for the asynchronous row lines; idles high.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      row_meta <= 4'hF;
      rows_s   <= 4'hF;
    end else begin
      row_meta <= row_i;
      rows_s   <= row_meta;
    end
  end

  // Row number of the latched single-low pattern.
  always_comb begin
    row_idx = 2'd0;
    case (row_pat)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  // Keypad legend: {row, column} -> key code.
  always_comb begin
    key_code = 4'h0;
    case ({row_idx, col_idx})
      4'h0: key_code = 4'h1;
      4'h1: key_code = 4'h2;
      4'h2: key_code = 4'h3;
      4'h3: key_code = 4'hA;
      4'h4: key_code = 4'h4;
      4'h5: key_code = 4'h5;
      4'h6: key_code = 4'h6;
      4'h7: key_code = 4'hB;
      4'h8: key_code = 4'h7;
      4'h9: key_code = 4'h8;
      4'hA: key_code = 4'h9;
      4'hB: key_code = 4'hC;
      4'hC: key_code = 4'hE;
      4'hD: key_code = 4'h0;
      4'hE: key_code = 4'hF;
      4'hF: key_code = 4'hD;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= SCAN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      SCAN: begin
        if ((cnt == SCAN_LAST) && single_low) state_nxt = DEBOUNCE;
      end
      DEBOUNCE: begin
        if (rows_s != row_pat)    state_nxt = SCAN;
        else if (cnt == DEB_LAST) state_nxt = PRESSED;
      end
      PRESSED: state_nxt = WAIT_RELEASE;
      WAIT_RELEASE: begin
        if (rows_idle) state_nxt = REL_DEBOUNCE;
      end
      REL_DEBOUNCE: begin
        if (!rows_idle)           state_nxt = WAIT_RELEASE;
        else if (cnt == DEB_LAST) state_nxt = SCAN;
      end
      default: state_nxt = SCAN;
    endcase
  end

  // Datapath and output next values; column index stays frozen outside SCAN
  // and steps to the next column whenever the scan resumes.
  always_comb begin
    cnt_nxt     = cnt;
    col_idx_nxt = col_idx;
    row_pat_nxt = row_pat;
    keypad_nxt  = keypad_o;
    detect_nxt  = 1'b0;
    held_nxt    = key_held_o;
    case (state)
      SCAN: begin
        if (cnt == SCAN_LAST) begin
          cnt_nxt = '0;
          if (single_low) row_pat_nxt = rows_s;
          else            col_idx_nxt = col_idx + 2'd1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      DEBOUNCE: begin
        if (rows_s != row_pat) begin
          cnt_nxt     = '0;
          col_idx_nxt = col_idx + 2'd1;
        end else if (cnt == DEB_LAST) begin
          cnt_nxt    = '0;
          detect_nxt = 1'b1;
          keypad_nxt = key_code;
          held_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      REL_DEBOUNCE: begin
        if (!rows_idle) begin
          cnt_nxt = '0;
        end else if (cnt == DEB_LAST) begin
          cnt_nxt     = '0;
          held_nxt    = 1'b0;
          col_idx_nxt = col_idx + 2'd1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: cnt_nxt = '0;
    endcase
  end

  // Registered datapath and outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt          <= '0;
      col_idx      <= 2'd0;
      row_pat      <= 4'hF;
      col_o        <= 4'b1110;
      keypad_o     <= 4'h0;
      key_detect_o <= 1'b0;
      key_held_o   <= 1'b0;
    end else begin
      cnt          <= cnt_nxt;
      col_idx      <= col_idx_nxt;
      row_pat      <= row_pat_nxt;
      col_o        <= ~(4'b0001 << col_idx_nxt);
      keypad_o     <= keypad_nxt;
      key_detect_o <= detect_nxt;
      key_held_o   <= held_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Brief    : Self-checking bench for keypad_scanner with a keypad matrix model
//            and a scoreboard of expected key codes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  localparam int SCAN_DIV        = 4;
  localparam int DEBOUNCE_CYCLES = 8;

  logic       clk = 1'b0;
  logic       reset_i;
  logic [3:0] row_i;
  logic [3:0] col_o;
  logic [3:0] keypad_o;
  logic       key_detect_o;
  logic       key_held_o;

  // Key contacts, index = row*4 + column; glitch override of the row lines.
  logic [15:0] key_down;
  logic        glitch_en;
  logic [3:0]  glitch_rows;

  int checks = 0;
  int errors = 0;
  int pulse_count = 0;
  int cyc = 0;
  int last_pulse_cyc = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_code;

  keypad_scanner #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .row_i        (row_i),
    .col_o        (col_o),
    .keypad_o     (keypad_o),
    .key_detect_o (key_detect_o),
    .key_held_o   (key_held_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Keypad matrix: a closed key pulls its row low while its column is driven low.
  always_comb begin
    row_i = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_down[r*4+c] && (col_o[c] === 1'b0)) row_i[r] = 1'b0;
    if (glitch_en) row_i = glitch_rows;
  end

  // Scoreboard: every detect pulse must match the oldest expected code.
  always @(negedge clk) begin
    if (key_detect_o === 1'b1) begin
      pulse_count    = pulse_count + 1;
      last_pulse_cyc = cyc;
      checks         = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_pulse keypad_o=%h required no pulse", keypad_o);
      end else begin
        exp_code = exp_q.pop_front();
        if (keypad_o !== exp_code) begin
          errors = errors + 1;
          $display("FAIL scoreboard_code keypad_o=%h required %h", keypad_o, exp_code);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pulse(input int start, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (pulse_count != start) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_held_low(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (key_held_o === 1'b0) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // Returns at the first sample on which col_o has just switched to target.
  task automatic align_col(input logic [3:0] target, output bit got);
    logic [3:0] prev;
    got  = 1'b0;
    prev = col_o;
    for (int i = 0; i < 40; i++) begin
      step();
      if ((col_o === target) && (prev !== target)) begin
        got = 1'b1;
        break;
      end
      prev = col_o;
    end
  endtask

  task automatic test_reset();
    logic [3:0] e;
    reset_i = 1'b1;
    repeat (3) @(posedge clk);
    step();
    reset_i = 1'b0;
    checks++; if (col_o !== 4'b1110) begin errors++; $display("FAIL reset_col col_o=%b required 1110", col_o); end
    checks++; if (keypad_o !== 4'h0) begin errors++; $display("FAIL reset_keypad keypad_o=%h required 0", keypad_o); end
    checks++; if (key_detect_o !== 1'b0) begin errors++; $display("FAIL reset_detect key_detect_o=%b required 0", key_detect_o); end
    checks++; if (key_held_o !== 1'b0) begin errors++; $display("FAIL reset_held key_held_o=%b required 0", key_held_o); end
    // Idle rotation: each column dwells SCAN_DIV cycles, starting at column 0.
    for (int i = 0; i < 16; i++) begin
      e = 4'b1111;
      e[(i / SCAN_DIV) % 4] = 1'b0;
      checks++;
      if (col_o !== e) begin errors++; $display("FAIL scan_rotation i=%0d col_o=%b required %b", i, col_o, e); end
      step();
    end
  endtask

  task automatic test_key6();
    int start;
    bit got;
    start = pulse_count;
    exp_q.push_back(4'h6);
    key_down[1*4+2] = 1'b1;
    wait_pulse(start, 60, got);
    checks++; if (!got) begin errors++; $display("FAIL key6_pulse timeout pulses=%0d required 1", pulse_count - start); end
    checks++; if (keypad_o !== 4'h6) begin errors++; $display("FAIL key6_code keypad_o=%h required 6", keypad_o); end
    repeat (100) step();
    checks++; if (pulse_count - start != 1) begin errors++; $display("FAIL key6_single pulses=%0d required 1", pulse_count - start); end
    checks++; if (col_o !== 4'b1011) begin errors++; $display("FAIL key6_col_frozen col_o=%b required 1011", col_o); end
    checks++; if (key_held_o !== 1'b1) begin errors++; $display("FAIL key6_held key_held_o=%b required 1", key_held_o); end
    key_down[1*4+2] = 1'b0;
    wait_held_low(30, got);
    checks++; if (!got) begin errors++; $display("FAIL key6_release timeout key_held_o=%b required 0", key_held_o); end
    checks++; if (col_o !== 4'b0111) begin errors++; $display("FAIL key6_resume_col col_o=%b required 0111", col_o); end
  endtask

  task automatic test_bounce_star();
    int start;
    int c0;
    bit got;
    align_col(4'b1110, got);
    checks++; if (!got) begin errors++; $display("FAIL star_align timeout col_o=%b required 1110", col_o); end
    start = pulse_count;
    c0    = cyc;
    exp_q.push_back(4'hE);
    key_down[3*4+0] = 1'b1;
    repeat (3) step();
    key_down[3*4+0] = 1'b0;
    step();
    key_down[3*4+0] = 1'b1;
    wait_pulse(start, 60, got);
    checks++; if (!got) begin errors++; $display("FAIL star_pulse timeout pulses=%0d required 1", pulse_count - start); end
    checks++; if (keypad_o !== 4'hE) begin errors++; $display("FAIL star_code keypad_o=%h required E", keypad_o); end
    // Bounce aborts the first debounce; the retry comes a full scan later and
    // then needs 8 matching cycles: pulse lands 30 cycles after contact.
    checks++; if (last_pulse_cyc - c0 != 30) begin errors++; $display("FAIL star_latency cycles=%0d required 30", last_pulse_cyc - c0); end
    repeat (10) step();
    checks++; if (pulse_count - start != 1) begin errors++; $display("FAIL star_single pulses=%0d required 1", pulse_count - start); end
    key_down[3*4+0] = 1'b0;
    wait_held_low(30, got);
    checks++; if (!got) begin errors++; $display("FAIL star_release timeout key_held_o=%b required 0", key_held_o); end
  endtask

  task automatic test_glitch();
    int start;
    bit got;
    align_col(4'b0111, got);
    checks++; if (!got) begin errors++; $display("FAIL glitch_align timeout col_o=%b required 0111", col_o); end
    start       = pulse_count;
    glitch_rows = 4'b1110;
    glitch_en   = 1'b1;
    repeat (5) step();
    glitch_en = 1'b0;
    repeat (2) step();
    checks++; if (col_o !== 4'b0111) begin errors++; $display("FAIL glitch_frozen col_o=%b required 0111", col_o); end
    step();
    checks++; if (col_o !== 4'b1110) begin errors++; $display("FAIL glitch_resume col_o=%b required 1110", col_o); end
    repeat (20) step();
    checks++; if (pulse_count != start) begin errors++; $display("FAIL glitch_no_pulse pulses=%0d required 0", pulse_count - start); end
    checks++; if (keypad_o !== 4'hE) begin errors++; $display("FAIL glitch_keypad keypad_o=%h required E", keypad_o); end
    checks++; if (key_held_o !== 1'b0) begin errors++; $display("FAIL glitch_held key_held_o=%b required 0", key_held_o); end
  endtask

  task automatic test_multi();
    int start;
    bit got;
    start = pulse_count;
    key_down[0*4+1] = 1'b1;
    key_down[2*4+1] = 1'b1;
    repeat (40) step();
    checks++; if (pulse_count != start) begin errors++; $display("FAIL multi_no_pulse pulses=%0d required 0", pulse_count - start); end
    exp_q.push_back(4'h2);
    key_down[2*4+1] = 1'b0;
    wait_pulse(start, 60, got);
    checks++; if (!got) begin errors++; $display("FAIL multi_pulse timeout pulses=%0d required 1", pulse_count - start); end
    checks++; if (keypad_o !== 4'h2) begin errors++; $display("FAIL multi_code keypad_o=%h required 2", keypad_o); end
    key_down[0*4+1] = 1'b0;
    wait_held_low(30, got);
    checks++; if (!got) begin errors++; $display("FAIL multi_release timeout key_held_o=%b required 0", key_held_o); end
  endtask

  task automatic test_release_bounce();
    int start;
    bit got;
    start = pulse_count;
    exp_q.push_back(4'hD);
    key_down[3*4+3] = 1'b1;
    wait_pulse(start, 60, got);
    checks++; if (!got) begin errors++; $display("FAIL keyd_pulse timeout pulses=%0d required 1", pulse_count - start); end
    checks++; if (keypad_o !== 4'hD) begin errors++; $display("FAIL keyd_code keypad_o=%h required D", keypad_o); end
    repeat (3) step();
    key_down[3*4+3] = 1'b0;
    repeat (4) step();
    key_down[3*4+3] = 1'b1;
    repeat (2) step();
    key_down[3*4+3] = 1'b0;
    // The second open stretch restarts the count; 8 idle cycles end at +17.
    repeat (10) step();
    checks++; if (key_held_o !== 1'b1) begin errors++; $display("FAIL keyd_held_early key_held_o=%b required 1", key_held_o); end
    step();
    checks++; if (key_held_o !== 1'b0) begin errors++; $display("FAIL keyd_held_drop key_held_o=%b required 0", key_held_o); end
    checks++; if (col_o !== 4'b1110) begin errors++; $display("FAIL keyd_resume_col col_o=%b required 1110", col_o); end
    repeat (10) step();
    checks++; if (pulse_count - start != 1) begin errors++; $display("FAIL keyd_single pulses=%0d required 1", pulse_count - start); end
  endtask

  task automatic test_reset_mid();
    int start;
    bit got;
    align_col(4'b1011, got);
    checks++; if (!got) begin errors++; $display("FAIL key9_align timeout col_o=%b required 1011", col_o); end
    start = pulse_count;
    key_down[2*4+2] = 1'b1;
    // Debounce starts 4 cycles in; 9 cycles in the counter holds 5.
    repeat (9) step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    checks++; if (col_o !== 4'b1110) begin errors++; $display("FAIL midreset_col col_o=%b required 1110", col_o); end
    checks++; if (keypad_o !== 4'h0) begin errors++; $display("FAIL midreset_keypad keypad_o=%h required 0", keypad_o); end
    checks++; if (key_detect_o !== 1'b0) begin errors++; $display("FAIL midreset_detect key_detect_o=%b required 0", key_detect_o); end
    checks++; if (key_held_o !== 1'b0) begin errors++; $display("FAIL midreset_held key_held_o=%b required 0", key_held_o); end
    step();
    checks++; if (key_detect_o !== 1'b0) begin errors++; $display("FAIL midreset_after key_detect_o=%b required 0", key_detect_o); end
    checks++; if (pulse_count != start) begin errors++; $display("FAIL midreset_no_pulse pulses=%0d required 0", pulse_count - start); end
    exp_q.push_back(4'h9);
    wait_pulse(start, 60, got);
    checks++; if (!got) begin errors++; $display("FAIL key9_pulse timeout pulses=%0d required 1", pulse_count - start); end
    checks++; if (keypad_o !== 4'h9) begin errors++; $display("FAIL key9_code keypad_o=%h required 9", keypad_o); end
    repeat (30) step();
    checks++; if (pulse_count - start != 1) begin errors++; $display("FAIL key9_single pulses=%0d required 1", pulse_count - start); end
    key_down[2*4+2] = 1'b0;
    wait_held_low(30, got);
    checks++; if (!got) begin errors++; $display("FAIL key9_release timeout key_held_o=%b required 0", key_held_o); end
  endtask

  initial begin
    reset_i     = 1'b1;
    key_down    = 16'h0;
    glitch_en   = 1'b0;
    glitch_rows = 4'hF;
    test_reset();
    test_key6();
    test_bounce_star();
    test_glitch();
    test_multi();
    test_release_bounce();
    test_reset_mid();
    repeat (5) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
